axi4_lite_master_ctrl: RTL and testbench
========================================

# axi4_lite_master_ctrl

Parametrised AXI4-Lite master engine that turns single-beat commands from a local valid/ready command port into AXI4-Lite read or write transactions and returns the outcome on a valid/ready response port. It succeeds the fixed-width master: independent AW/W handshakes in either order, user byte strobes, full 2-bit RESP reporting, a held response handshake and a per-phase timeout with abort. It sits between on-chip control logic (register sequencers, test drivers) and an AXI4-Lite interconnect.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; legal values 32 or 64.
- TIMEOUT_CYCLES, 256, max cycles spent waiting in one bus phase; 0 disables timeout.
- ACLK  input  1  clock, all logic on rising edge.
- ARESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  engine accepts command.
- CMD_WRITE  input  1  1 = write, 0 = read.
- CMD_ADDR  input  ADDR_WIDTH  byte address.
- CMD_WDATA  input  DATA_WIDTH  write data.
- CMD_WSTRB  input  DATA_WIDTH/8  write byte enables.
- RSP_VALID  output  1  response available.
- RSP_READY  input  1  consumer takes response.
- RSP_WRITE  output  1  response belongs to a write.
- RSP_RDATA  output  DATA_WIDTH  read data (0 for writes and timeouts).
- RSP_RESP  output  2  AXI RESP of the transaction; 2'b10 on timeout.
- RSP_TIMEOUT  output  1  transaction aborted by timeout.
- M_AWADDR, M_AWVALID, M_AWREADY; M_WDATA, M_WSTRB, M_WVALID, M_WREADY; M_BRESP[1:0], M_BVALID, M_BREADY; M_ARADDR, M_ARVALID, M_ARREADY; M_RDATA, M_RRESP[1:0], M_RVALID, M_RREADY: standard AXI4-Lite master-side channels, widths per parameters.

## Operation
- States: IDLE, WRITE (AW+W), WRESP, RADDR, RDATA, RESP.
- IDLE: CMD_READY=1 only here. On CMD_VALID&&CMD_READY, register addr/data/strb/write; go WRITE or RADDR.
- Address outputs carry the registered address with low log2(DATA_WIDTH/8) bits forced to 0.
- WRITE: M_AWVALID and M_WVALID asserted together; each drops independently after its own handshake (aw_done, w_done flags). Leave to WRESP when both done, including same-cycle completion of the second.
- WRESP: M_BREADY=1; on M_BVALID capture M_BRESP, go RESP.
- RADDR: M_ARVALID=1; on M_ARREADY go RDATA. RDATA: M_RREADY=1; on M_RVALID capture M_RDATA and M_RRESP, go RESP.
- RESP: RSP_VALID=1, fields stable; on RSP_READY go IDLE. No new command accepted until the response is taken.
- Timeout: counter cleared on entering any bus state and on every AW/W handshake; increments each cycle in WRITE/WRESP/RADDR/RDATA. When counter == TIMEOUT_CYCLES-1 and the phase does not complete that cycle, all M_*VALID/READY drop next cycle, go RESP with RSP_TIMEOUT=1, RSP_RESP=2'b10, RSP_RDATA=0. Completion in the same cycle as expiry wins (normal response).
- Valid/ready-driven outputs and data/address are registered; M_WDATA/M_WSTRB/addresses are 0 when their VALID is low.

## Timing
- Reset (asynchronous): state IDLE, all M_*VALID, M_BREADY, M_RREADY, RSP_VALID, RSP_TIMEOUT = 0; addr/data/resp outputs 0; CMD_READY=1 from first clock after release (0 while ARESET high).
- Reset mid-transaction: outputs drop immediately, no response issued.
- Command accepted at edge N: VALIDs high from cycle N+1.
- Zero-wait write: AW/W handshake at N+1, M_BREADY at N+2, M_BVALID at N+2 -> RSP_VALID at N+3. Same latency for zero-wait read.
- CMD_READY returns 1 the cycle after the RSP handshake; back-to-back command issue rate is one per 4 cycles minimum.

## Test plan
- Write addr 0x1003, data 0xDEADBEEF, strb 4'b0101, slave zero-wait, BRESP 00 -> M_AWADDR=0x1000, M_WSTRB=0101 at N+1, RSP_VALID at N+3 with RSP_WRITE=1, RSP_RESP=00.
- Write with M_WREADY at N+1 and M_AWREADY delayed to N+4 -> M_WVALID low from N+2, M_AWVALID held to N+4, M_BREADY from N+5.
- Read 0x20, slave returns 0x12345678 with RRESP 2'b10 after 3-cycle RVALID wait -> RSP_RDATA=0x12345678, RSP_RESP=10, RSP_TIMEOUT=0.
- TIMEOUT_CYCLES=4, M_ARREADY stuck 0 -> M_ARVALID high N+1..N+4, low at N+5, RSP_VALID at N+5 with RSP_TIMEOUT=1, RSP_RESP=10; repeat with ARREADY at N+4 -> normal read.
- Hold RSP_READY=0 for 5 cycles with CMD_VALID high -> response fields stable, CMD_READY=0 throughout; next command accepted cycle after RSP_READY.
- Assert ARESET during WRESP -> M_BREADY=0 immediately, no RSP_VALID; after release a fresh read completes normally.

Source files
------------

// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite master engine: single-beat commands in, AXI4-Lite read/write transactions out,
// with independent AW/W handshakes, held response handshake and per-phase timeout abort.
module axi4_lite_master_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic                    RSP_WRITE,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ALIGN_BITS = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;

  state_t                 state, state_d;
  logic [CNT_WIDTH-1:0]   cnt, cnt_d;
  logic                   cmd_ready_d, rsp_valid_d, rsp_write_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_d, wdata_d;
  logic [1:0]             rsp_resp_d;
  logic [ADDR_WIDTH-1:0]  awaddr_d, araddr_d;
  logic [STRB_WIDTH-1:0]  wstrb_d;
  logic                   awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                   aw_fire, w_fire, expire, abort;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      cnt         <= '0;
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_WRITE   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_RESP    <= 2'b00;
      RSP_TIMEOUT <= 1'b0;
      M_AWADDR    <= '0;
      M_AWVALID   <= 1'b0;
      M_WDATA     <= '0;
      M_WSTRB     <= '0;
      M_WVALID    <= 1'b0;
      M_BREADY    <= 1'b0;
      M_ARADDR    <= '0;
      M_ARVALID   <= 1'b0;
      M_RREADY    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      CMD_READY   <= cmd_ready_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_WRITE   <= rsp_write_d;
      RSP_RDATA   <= rsp_rdata_d;
      RSP_RESP    <= rsp_resp_d;
      RSP_TIMEOUT <= rsp_timeout_d;
      M_AWADDR    <= awaddr_d;
      M_AWVALID   <= awvalid_d;
      M_WDATA     <= wdata_d;
      M_WSTRB     <= wstrb_d;
      M_WVALID    <= wvalid_d;
      M_BREADY    <= bready_d;
      M_ARADDR    <= araddr_d;
      M_ARVALID   <= arvalid_d;
      M_RREADY    <= rready_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = '0;
    abort         = 1'b0;
    rsp_valid_d   = RSP_VALID;
    rsp_write_d   = RSP_WRITE;
    rsp_rdata_d   = RSP_RDATA;
    rsp_resp_d    = RSP_RESP;
    rsp_timeout_d = RSP_TIMEOUT;
    awaddr_d      = M_AWADDR;
    awvalid_d     = M_AWVALID;
    wdata_d       = M_WDATA;
    wstrb_d       = M_WSTRB;
    wvalid_d      = M_WVALID;
    araddr_d      = M_ARADDR;
    arvalid_d     = M_ARVALID;
    bready_d      = 1'b0;
    rready_d      = 1'b0;
    aw_fire       = M_AWVALID & M_AWREADY;
    w_fire        = M_WVALID & M_WREADY;
    expire        = (TIMEOUT_CYCLES != 0) && (cnt == CNT_WIDTH'(TO_LAST));

    case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          if (CMD_WRITE) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            awaddr_d  = CMD_ADDR & ADDR_MASK;
            wvalid_d  = 1'b1;
            wdata_d   = CMD_WDATA;
            wstrb_d   = CMD_WSTRB;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
            araddr_d  = CMD_ADDR & ADDR_MASK;
          end
        end
      end
      // AW and W retire independently; a handshake on either restarts the timer
      WRITE: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          awaddr_d  = '0;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
        end
        if ((!M_AWVALID || aw_fire) && (!M_WVALID || w_fire)) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end else if (!(aw_fire || w_fire)) begin
          if (expire) abort = 1'b1;
          else        cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      WRESP: begin
        if (M_BVALID) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = M_BRESP;
          rsp_timeout_d = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end else begin
          bready_d = 1'b1;
          cnt_d    = cnt + CNT_WIDTH'(1);
        end
      end
      RADDR: begin
        if (M_ARREADY) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          araddr_d  = '0;
          rready_d  = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      RDATA: begin
        if (M_RVALID) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = M_RDATA;
          rsp_resp_d    = M_RRESP;
          rsp_timeout_d = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end else begin
          rready_d = 1'b1;
          cnt_d    = cnt + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b0;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b00;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timed-out phase: drop every bus request and report SLVERR with the timeout flag
    if (abort) begin
      state_d       = RESP;
      awvalid_d     = 1'b0;
      awaddr_d      = '0;
      wvalid_d      = 1'b0;
      wdata_d       = '0;
      wstrb_d       = '0;
      arvalid_d     = 1'b0;
      araddr_d      = '0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_write_d   = (state == WRITE) || (state == WRESP);
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Directed bench for axi4_lite_master_ctrl with a 4-cycle phase timeout.
module tb_axi4_lite_master_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [3:0]  CMD_WSTRB;
  logic        RSP_VALID, RSP_READY, RSP_WRITE, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [1:0]  M_BRESP, M_RRESP;

  int tests_run = 0;
  int fails = 0;

  axi4_lite_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .RSP_TIMEOUT(RSP_TIMEOUT),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Inputs are changed and outputs sampled on the falling edge
  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0; CMD_WSTRB = 0; RSP_READY = 0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
    tick(); tick();
    tests_run++; if ({CMD_READY, RSP_VALID, RSP_TIMEOUT, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY} !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %b want 00000000", {CMD_READY, RSP_VALID, RSP_TIMEOUT, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}); end
    tests_run++; if ({M_AWADDR, M_ARADDR, M_WDATA, RSP_RDATA, RSP_RESP} !== 130'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {M_AWADDR, M_ARADDR, M_WDATA, RSP_RDATA, RSP_RESP}); end
    ARESET = 1'b0;
    tick();
    tests_run++; if (CMD_READY !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", CMD_READY); end
  endtask

  task automatic test_write_basic();
    tick();
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h1003; CMD_WDATA = 32'hDEADBEEF; CMD_WSTRB = 4'b0101;
    tick(); // N+1
    CMD_VALID = 0;
    tests_run++; if ({M_AWVALID, M_WVALID, CMD_READY, M_BREADY} !== 4'b1100) begin fails++; $display("FAIL wr_valids: got %b want 1100", {M_AWVALID, M_WVALID, CMD_READY, M_BREADY}); end
    tests_run++; if (M_AWADDR !== 32'h1000) begin fails++; $display("FAIL wr_awaddr: got %h want 00001000", M_AWADDR); end
    tests_run++; if ({M_WDATA, M_WSTRB} !== {32'hDEADBEEF, 4'b0101}) begin fails++; $display("FAIL wr_wdata_strb: got %h %b want deadbeef 0101", M_WDATA, M_WSTRB); end
    M_AWREADY = 1; M_WREADY = 1;
    tick(); // N+2
    M_AWREADY = 0; M_WREADY = 0;
    tests_run++; if ({M_AWVALID, M_WVALID, M_BREADY, RSP_VALID} !== 4'b0010) begin fails++; $display("FAIL wr_bready: got %b want 0010", {M_AWVALID, M_WVALID, M_BREADY, RSP_VALID}); end
    tests_run++; if ({M_AWADDR, M_WSTRB} !== 36'h0) begin fails++; $display("FAIL wr_idle_zero: got %h want 0", {M_AWADDR, M_WSTRB}); end
    M_BVALID = 1; M_BRESP = 2'b00;
    tick(); // N+3
    M_BVALID = 0;
    tests_run++; if ({RSP_VALID, RSP_WRITE, RSP_TIMEOUT, M_BREADY, RSP_RESP} !== 6'b110000) begin fails++; $display("FAIL wr_rsp: got %b want 110000", {RSP_VALID, RSP_WRITE, RSP_TIMEOUT, M_BREADY, RSP_RESP}); end
    tests_run++; if (RSP_RDATA !== 32'h0) begin fails++; $display("FAIL wr_rsp_rdata: got %h want 0", RSP_RDATA); end
    RSP_READY = 1;
    tick(); // N+4
    RSP_READY = 0;
    tests_run++; if ({RSP_VALID, CMD_READY} !== 2'b01) begin fails++; $display("FAIL wr_return_idle: got %b want 01", {RSP_VALID, CMD_READY}); end
  endtask

  task automatic test_write_aw_late();
    tick();
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h2008; CMD_WDATA = 32'hA5A50001; CMD_WSTRB = 4'b1111;
    tick(); // N+1
    CMD_VALID = 0;
    M_WREADY = 1;
    tick(); // N+2
    M_WREADY = 0;
    tests_run++; if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b100) begin fails++; $display("FAIL awlate_n2: got %b want 100", {M_AWVALID, M_WVALID, M_BREADY}); end
    tests_run++; if ({M_WDATA, M_WSTRB} !== 36'h0) begin fails++; $display("FAIL awlate_wdata_zero: got %h want 0", {M_WDATA, M_WSTRB}); end
    tick(); // N+3
    tests_run++; if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b100) begin fails++; $display("FAIL awlate_n3: got %b want 100", {M_AWVALID, M_WVALID, M_BREADY}); end
    tick(); // N+4
    tests_run++; if ({M_AWVALID, M_AWADDR} !== {1'b1, 32'h2008}) begin fails++; $display("FAIL awlate_n4: got %b %h want 1 00002008", M_AWVALID, M_AWADDR); end
    M_AWREADY = 1;
    tick(); // N+5
    M_AWREADY = 0;
    tests_run++; if ({M_AWVALID, M_BREADY, RSP_VALID} !== 3'b010) begin fails++; $display("FAIL awlate_n5: got %b want 010", {M_AWVALID, M_BREADY, RSP_VALID}); end
    M_BVALID = 1; M_BRESP = 2'b01;
    tick(); // N+6
    M_BVALID = 0;
    tests_run++; if ({RSP_VALID, RSP_WRITE, RSP_TIMEOUT, RSP_RESP} !== 5'b11001) begin fails++; $display("FAIL awlate_rsp: got %b want 11001", {RSP_VALID, RSP_WRITE, RSP_TIMEOUT, RSP_RESP}); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
  endtask

  task automatic test_read_slow();
    tick();
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h20;
    tick(); // N+1
    CMD_VALID = 0;
    tests_run++; if ({M_ARVALID, M_ARADDR, M_AWVALID} !== {1'b1, 32'h20, 1'b0}) begin fails++; $display("FAIL rd_ar: got %b %h %b want 1 00000020 0", M_ARVALID, M_ARADDR, M_AWVALID); end
    M_ARREADY = 1;
    tick(); // N+2
    M_ARREADY = 0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if ({M_ARVALID, M_RREADY, RSP_VALID} !== 3'b010) begin fails++; $display("FAIL rd_wait%0d: got %b want 010", i, {M_ARVALID, M_RREADY, RSP_VALID}); end
      tick();
    end
    // N+5: data arrives on the last cycle before the timeout would fire
    M_RVALID = 1; M_RDATA = 32'h12345678; M_RRESP = 2'b10;
    tick(); // N+6
    M_RVALID = 0;
    tests_run++; if ({RSP_VALID, RSP_WRITE, RSP_TIMEOUT, M_RREADY, RSP_RESP} !== 6'b100010) begin fails++; $display("FAIL rd_rsp: got %b want 100010", {RSP_VALID, RSP_WRITE, RSP_TIMEOUT, M_RREADY, RSP_RESP}); end
    tests_run++; if (RSP_RDATA !== 32'h12345678) begin fails++; $display("FAIL rd_rdata: got %h want 12345678", RSP_RDATA); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
  endtask

  task automatic test_timeout();
    // Read with ARREADY never asserted
    tick();
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h44;
    tick(); // N+1
    CMD_VALID = 0;
    for (int i = 1; i <= 4; i++) begin
      tests_run++; if ({M_ARVALID, RSP_VALID} !== 2'b10) begin fails++; $display("FAIL to_rd_arvalid_n%0d: got %b want 10", i, {M_ARVALID, RSP_VALID}); end
      if (i < 4) tick();
    end
    tick(); // N+5
    tests_run++; if ({M_ARVALID, M_RREADY, RSP_VALID, RSP_TIMEOUT, RSP_WRITE, RSP_RESP} !== 7'b0011010) begin fails++; $display("FAIL to_rd_rsp: got %b want 0011010", {M_ARVALID, M_RREADY, RSP_VALID, RSP_TIMEOUT, RSP_WRITE, RSP_RESP}); end
    tests_run++; if ({RSP_RDATA, M_ARADDR} !== 64'h0) begin fails++; $display("FAIL to_rd_zero: got %h want 0", {RSP_RDATA, M_ARADDR}); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
    // Same read, ARREADY arrives on the expiry cycle: completion wins
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h48;
    tick(); // N+1
    CMD_VALID = 0;
    tick(); tick(); tick(); // N+4
    tests_run++; if (M_ARVALID !== 1'b1) begin fails++; $display("FAIL to_edge_arvalid: got %b want 1", M_ARVALID); end
    M_ARREADY = 1;
    tick(); // N+5
    M_ARREADY = 0;
    tests_run++; if ({M_ARVALID, M_RREADY, RSP_VALID} !== 3'b010) begin fails++; $display("FAIL to_edge_rready: got %b want 010", {M_ARVALID, M_RREADY, RSP_VALID}); end
    M_RVALID = 1; M_RDATA = 32'hCAFE0001; M_RRESP = 2'b00;
    tick(); // N+6
    M_RVALID = 0;
    tests_run++; if ({RSP_VALID, RSP_TIMEOUT, RSP_RESP, RSP_RDATA} !== {4'b1000, 32'hCAFE0001}) begin fails++; $display("FAIL to_edge_rsp: got %b %h want 1000 cafe0001", {RSP_VALID, RSP_TIMEOUT, RSP_RESP}, RSP_RDATA); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
    // Write with neither AWREADY nor WREADY
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h50; CMD_WDATA = 32'h1; CMD_WSTRB = 4'hF;
    tick(); // N+1
    CMD_VALID = 0;
    tick(); tick(); tick(); // N+4
    tests_run++; if ({M_AWVALID, M_WVALID, RSP_VALID} !== 3'b110) begin fails++; $display("FAIL to_wr_n4: got %b want 110", {M_AWVALID, M_WVALID, RSP_VALID}); end
    tick(); // N+5
    tests_run++; if ({M_AWVALID, M_WVALID, M_BREADY, RSP_VALID, RSP_TIMEOUT, RSP_WRITE, RSP_RESP} !== 8'b00011110) begin fails++; $display("FAIL to_wr_rsp: got %b want 00011110", {M_AWVALID, M_WVALID, M_BREADY, RSP_VALID, RSP_TIMEOUT, RSP_WRITE, RSP_RESP}); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
  endtask

  task automatic test_rsp_hold();
    tick();
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h60;
    tick(); // N+1: queue a write command behind the read
    CMD_WRITE = 1; CMD_ADDR = 32'h64; CMD_WDATA = 32'h11223344; CMD_WSTRB = 4'b1111;
    M_ARREADY = 1;
    tick(); // N+2
    M_ARREADY = 0;
    M_RVALID = 1; M_RDATA = 32'h55AA33CC; M_RRESP = 2'b01;
    tick(); // N+3
    M_RVALID = 0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if ({RSP_VALID, RSP_WRITE, RSP_TIMEOUT, CMD_READY, RSP_RESP} !== 6'b100001) begin fails++; $display("FAIL hold_ctrl%0d: got %b want 100001", i, {RSP_VALID, RSP_WRITE, RSP_TIMEOUT, CMD_READY, RSP_RESP}); end
      tests_run++; if (RSP_RDATA !== 32'h55AA33CC) begin fails++; $display("FAIL hold_rdata%0d: got %h want 55aa33cc", i, RSP_RDATA); end
      tick();
    end
    RSP_READY = 1; // N+8
    tick(); // N+9
    RSP_READY = 0;
    tests_run++; if ({RSP_VALID, CMD_READY, M_AWVALID} !== 3'b010) begin fails++; $display("FAIL hold_release: got %b want 010", {RSP_VALID, CMD_READY, M_AWVALID}); end
    tick(); // N+10: queued write accepted at the previous edge
    CMD_VALID = 0;
    tests_run++; if ({M_AWVALID, M_WVALID, CMD_READY, M_AWADDR} !== {3'b110, 32'h64}) begin fails++; $display("FAIL hold_next_cmd: got %b %h want 110 00000064", {M_AWVALID, M_WVALID, CMD_READY}, M_AWADDR); end
    M_AWREADY = 1; M_WREADY = 1;
    tick();
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 1; M_BRESP = 2'b11;
    tick();
    M_BVALID = 0;
    tests_run++; if ({RSP_VALID, RSP_WRITE, RSP_RESP} !== 4'b1111) begin fails++; $display("FAIL hold_wr_rsp: got %b want 1111", {RSP_VALID, RSP_WRITE, RSP_RESP}); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
  endtask

  task automatic test_reset_mid();
    tick();
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h70; CMD_WDATA = 32'h7; CMD_WSTRB = 4'b0001;
    tick(); // N+1
    CMD_VALID = 0; M_AWREADY = 1; M_WREADY = 1;
    tick(); // N+2: in WRESP
    M_AWREADY = 0; M_WREADY = 0;
    tests_run++; if (M_BREADY !== 1'b1) begin fails++; $display("FAIL mid_bready_pre: got %b want 1", M_BREADY); end
    ARESET = 1'b1;
    #1;
    tests_run++; if ({M_BREADY, RSP_VALID, CMD_READY, M_AWVALID, M_WVALID} !== 5'b00000) begin fails++; $display("FAIL mid_async_drop: got %b want 00000", {M_BREADY, RSP_VALID, CMD_READY, M_AWVALID, M_WVALID}); end
    M_BVALID = 1;
    tick();
    ARESET = 1'b0;
    tick();
    M_BVALID = 0;
    tests_run++; if ({RSP_VALID, M_BREADY, CMD_READY} !== 3'b001) begin fails++; $display("FAIL mid_after_release: got %b want 001", {RSP_VALID, M_BREADY, CMD_READY}); end
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h30;
    tick(); // N+1
    CMD_VALID = 0; M_ARREADY = 1;
    tests_run++; if ({M_ARVALID, M_ARADDR} !== {1'b1, 32'h30}) begin fails++; $display("FAIL mid_rd_ar: got %b %h want 1 00000030", M_ARVALID, M_ARADDR); end
    tick(); // N+2
    M_ARREADY = 0; M_RVALID = 1; M_RDATA = 32'h0BADF00D; M_RRESP = 2'b00;
    tick(); // N+3
    M_RVALID = 0;
    tests_run++; if ({RSP_VALID, RSP_WRITE, RSP_TIMEOUT, RSP_RESP, RSP_RDATA} !== {5'b10000, 32'h0BADF00D}) begin fails++; $display("FAIL mid_rd_rsp: got %b %h want 10000 0badf00d", {RSP_VALID, RSP_WRITE, RSP_TIMEOUT, RSP_RESP}, RSP_RDATA); end
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
    tests_run++; if ({RSP_VALID, CMD_READY} !== 2'b01) begin fails++; $display("FAIL mid_rd_idle: got %b want 01", {RSP_VALID, CMD_READY}); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_aw_late();
    test_read_slow();
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule
